mac_dot_sequencer: RTL

Sequencer that computes one signed dot product of two 14-bit vectors held in an external synchronous-read memory, by driving the team's existing 14x14->28-bit saturating MAC (synchronous active-high `reset`, `valid_in`/`valid_out`, 2-cycle latency from `valid_in` to `valid_out`). It sits between a job requester and the MAC:

- clears the accumulator before each job;
- streams element pairs with optional stall;
- counts retired products;
- returns the accumulated result over a valid/ready handshake.

---
 rtl/mac_seq_pkg.sv | 26 ++
 rtl/mac_dot_sequencer_if.sv | 52 +++++
 rtl/mac_seq_counter.sv | 30 +++
 rtl/mac_dot_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the dot-product sequencer and its helpers.
package mac_seq_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 14;
    localparam int ACC_W  = 28;

    // Slot indices of the two counter instances
    localparam int CNT_ISSUE  = 0;
    localparam int CNT_RETIRE = 1;
    localparam int CNT_NUM    = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } mac_seq_state_t;

    // MAC results are only meaningful while a job has products in flight
    function automatic logic in_retire_window(input mac_seq_state_t st);
        return (st == ISSUE) || (st == DRAIN);
    endfunction

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Bundle of requester, memory, MAC and result signals around the sequencer.
interface mac_dot_sequencer_if #(
    parameter int ADDR_W = mac_seq_pkg::ADDR_W,
    parameter int DATA_W = mac_seq_pkg::DATA_W,
    parameter int ACC_W  = mac_seq_pkg::ACC_W
);
    logic                     start;
    logic [ADDR_W:0]          len;
    logic                     hold;
    logic                     busy;

    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_a_data;
    logic signed [DATA_W-1:0] mem_b_data;

    logic                     mac_reset;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic                     mac_valid_in;
    logic signed [ACC_W-1:0]  mac_f;
    logic                     mac_valid_out;

    logic signed [ACC_W-1:0]  res_data;
    logic                     res_valid;
    logic                     res_ready;

    // Sequencer side
    modport master (
        input  start, len, hold,
        input  mem_a_data, mem_b_data,
        input  mac_f, mac_valid_out,
        input  res_ready,
        output busy,
        output mem_rd_en, mem_addr,
        output mac_reset, mac_a, mac_b, mac_valid_in,
        output res_data, res_valid
    );

    // Requester / memory / MAC side
    modport slave (
        output start, len, hold,
        output mem_a_data, mem_b_data,
        output mac_f, mac_valid_out,
        output res_ready,
        input  busy,
        input  mem_rd_en, mem_addr,
        input  mac_reset, mac_a, mac_b, mac_valid_in,
        input  res_data, res_valid
    );

endinterface

// File: rtl/mac_seq_counter.sv
// Clearable up-counter with an equality flag against a supplied compare value.
module mac_seq_counter #(
    parameter int CNT_W = mac_seq_pkg::ADDR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0] count,
    output logic             at_cmp
);

    logic [CNT_W-1:0] count_reg;

    // Clear wins over increment so a new job always starts from zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count  = count_reg;
    assign at_cmp = (count_reg == cmp_val);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Streams element pairs from memory into the saturating MAC and returns one dot product per job.
module mac_dot_sequencer #(
    parameter int ADDR_W = mac_seq_pkg::ADDR_W,
    parameter int DATA_W = mac_seq_pkg::DATA_W,
    parameter int ACC_W  = mac_seq_pkg::ACC_W
) (
    input  logic                clk,
    input  logic                reset_n,
    mac_dot_sequencer_if.master bus
);

    import mac_seq_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    mac_seq_state_t state_reg;
    mac_seq_state_t state_next;

    logic [CNT_W-1:0]        len_reg;
    logic [CNT_W-1:0]        last_idx;
    logic                    valid_in_reg;
    logic                    mac_reset_reg;
    logic signed [ACC_W-1:0] res_data_reg;

    logic                    job_start;
    logic                    zero_result;
    logic                    rd_en;
    logic                    retire_fire;
    logic                    res_capture;

    logic [CNT_NUM-1:0]      cnt_inc;
    logic [CNT_NUM-1:0]      cnt_last;
    logic [CNT_W-1:0]        cnt_value [CNT_NUM];
    logic                    unused_cnt_bits;

    // Both counters stop one short of len: the index of the final element
    assign last_idx = len_reg - CNT_W'(1);

    assign cnt_inc[CNT_ISSUE]  = rd_en;
    assign cnt_inc[CNT_RETIRE] = retire_fire;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_NUM; gi++) begin : g_cnt
            mac_seq_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (job_start),
                .inc     (cnt_inc[gi]),
                .cmp_val (last_idx),
                .count   (cnt_value[gi]),
                .at_cmp  (cnt_last[gi])
            );
        end
    endgenerate

    assign unused_cnt_bits = &{1'b0, cnt_value[CNT_RETIRE], cnt_value[CNT_ISSUE][ADDR_W]};

    assign retire_fire = bus.mac_valid_out && in_retire_window(state_reg);

    always_comb begin
        state_next  = state_reg;
        job_start   = 1'b0;
        zero_result = 1'b0;
        rd_en       = 1'b0;
        res_capture = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        zero_result = 1'b1;
                        state_next  = DONE;
                    end else begin
                        job_start  = 1'b1;
                        state_next = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                if (!bus.hold) begin
                    rd_en = 1'b1;
                    if (cnt_last[CNT_ISSUE]) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.mac_valid_out && cnt_last[CNT_RETIRE]) begin
                    res_capture = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_reg <= '0;
        end else if (job_start) begin
            len_reg <= bus.len;
        end
    end

    // Memory data lands one cycle after the read strobe, so valid follows one stage behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_in_reg <= 1'b0;
        end else begin
            valid_in_reg <= rd_en;
        end
    end

    // Held high through reset so the MAC flushes on the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_reset_reg <= 1'b1;
        end else begin
            mac_reset_reg <= (state_next == CLEAR);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_data_reg <= '0;
        end else if (zero_result) begin
            res_data_reg <= '0;
        end else if (res_capture) begin
            res_data_reg <= bus.mac_f;
        end
    end

    assign bus.busy         = (state_reg != IDLE);
    assign bus.mem_rd_en    = rd_en;
    assign bus.mem_addr     = cnt_value[CNT_ISSUE][ADDR_W-1:0];
    assign bus.mac_reset    = mac_reset_reg;
    assign bus.mac_valid_in = valid_in_reg;
    assign bus.mac_a        = bus.mem_a_data;
    assign bus.mac_b        = bus.mem_b_data;
    assign bus.res_data     = res_data_reg;
    assign bus.res_valid    = (state_reg == DONE);

endmodule
